// File: rtl/seq_detect_multi.sv
// Runtime-configurable serial pattern detector. It compares NUM_PAT programmable PAT_LEN-bit
// patterns against a qualified bit stream and keeps a saturating count of match events.
module seq_detect_multi #(
  parameter int                         PAT_LEN = 4,
  parameter int                         NUM_PAT = 2,
  parameter int                         OVERLAP = 1,
  parameter int                         CNT_W   = 8,
  parameter logic [NUM_PAT*PAT_LEN-1:0] PAT_RST = {4'b1101, 4'b0101}
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       din,
  input  logic                       din_valid,
  input  logic                       cfg_load,
  input  logic [NUM_PAT*PAT_LEN-1:0] pat_cfg,
  input  logic                       cnt_clr,
  output logic [NUM_PAT-1:0]         match_vec,
  output logic                       dout,
  output logic [CNT_W-1:0]           match_cnt
);

  localparam int                 FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

  logic [NUM_PAT*PAT_LEN-1:0] pat_r;
  logic [PAT_LEN-1:0]         hist_r;
  logic [FILL_W-1:0]          fill_r;
  logic [NUM_PAT-1:0]         match_vec_r;
  logic                       dout_r;
  logic [CNT_W-1:0]           cnt_r;

  logic [PAT_LEN-1:0]         hist_nxt_s;
  logic [FILL_W-1:0]          fill_inc_s;
  logic [NUM_PAT-1:0]         hit_s;
  logic                       any_hit_s;
  logic                       accept_s;

  // Next-state history/fill for an accepted bit and the per-pattern hits they produce.
  always_comb begin
    hist_nxt_s = {hist_r[PAT_LEN-2:0], din};
    if (fill_r == FILL_FULL) begin
      fill_inc_s = fill_r;
    end else begin
      fill_inc_s = fill_r + FILL_W'(1);
    end
    hit_s = {NUM_PAT{1'b0}};
    for (int i = 0; i < NUM_PAT; i++) begin
      hit_s[i] = (hist_nxt_s == pat_r[i*PAT_LEN +: PAT_LEN]) && (fill_inc_s == FILL_FULL);
    end
    any_hit_s = |hit_s;
    accept_s  = din_valid & ~cfg_load;
  end

  // Pattern store, shift history, fill level and registered match flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_r       <= PAT_RST;
      hist_r      <= {PAT_LEN{1'b0}};
      fill_r      <= {FILL_W{1'b0}};
      match_vec_r <= {NUM_PAT{1'b0}};
      dout_r      <= 1'b0;
    end else if (cfg_load) begin
      pat_r       <= pat_cfg;
      hist_r      <= {PAT_LEN{1'b0}};
      fill_r      <= {FILL_W{1'b0}};
      match_vec_r <= {NUM_PAT{1'b0}};
      dout_r      <= 1'b0;
    end else if (din_valid) begin
      hist_r      <= hist_nxt_s;
      // Non-overlapping mode forgets the matched bits by emptying the fill level.
      if ((OVERLAP == 0) && any_hit_s) begin
        fill_r <= {FILL_W{1'b0}};
      end else begin
        fill_r <= fill_inc_s;
      end
      match_vec_r <= hit_s;
      dout_r      <= any_hit_s;
    end else begin
      match_vec_r <= {NUM_PAT{1'b0}};
      dout_r      <= 1'b0;
    end
  end

  // Saturating event counter; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s && any_hit_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign match_vec = match_vec_r;
  assign dout      = dout_r;
  assign match_cnt = cnt_r;

endmodule
